// File: rtl/arm_mem_bridge.sv
// -----------------------------------------------------------------------------
// arm_mem_bridge
//   Wait-state memory bridge between the multicycle ARM core and a
//   variable-latency memory. Accepts one core request at a time, holds it on a
//   valid/ready memory port, and returns a one-cycle done pulse with read data.
//   Misaligned accesses and memory timeouts complete as bus errors and bump a
//   saturating debug error counter.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous active-low reset
//   core_req    1-cycle request strobe, sampled only in IDLE
//   core_we     1 = write, 0 = read
//   core_adr    request address
//   core_wdata  write data
//   core_busy   bridge not idle; core must hold its FSM
//   core_done   1-cycle completion pulse
//   core_err    qualifies core_done: access failed
//   core_rdata  read data, valid only while core_done = 1
//   mem_valid   request present on the memory port
//   mem_we      registered core_we
//   mem_adr     registered core_adr
//   mem_wdata   registered core_wdata
//   mem_ready   memory accepts/completes while mem_valid = 1
//   mem_rdata   read data, sampled on mem_valid & mem_ready
//   err_count   saturating error count since reset
// -----------------------------------------------------------------------------
module arm_mem_bridge #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                TIMEOUT     = 16,
  parameter logic [DATA_W-1:0] ERR_DATA    = DATA_W'(32'hDEADBEEF),
  parameter bit                ALIGN_CHECK = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_adr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_busy,
  output logic              core_done,
  output logic              core_err,
  output logic [DATA_W-1:0] core_rdata,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [7:0]        err_count
);

  localparam int             CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_ERR
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                r_busy;
  logic                r_done, w_done_nxt;
  logic                r_err, w_err_nxt;
  logic [DATA_W-1:0]   r_rdata, w_rdata_nxt;
  logic                r_mem_valid, w_mem_valid_nxt;
  logic                r_mem_we, w_mem_we_nxt;
  logic [ADDR_W-1:0]   r_mem_adr, w_mem_adr_nxt;
  logic [DATA_W-1:0]   r_mem_wdata, w_mem_wdata_nxt;
  logic [7:0]          r_err_cnt, w_err_cnt_nxt;
  logic                w_err_evt;
  logic                w_misaligned;

  assign w_misaligned = ALIGN_CHECK && (core_adr[1:0] != 2'b00);

  // Next-state and next-output logic. Every completion output is computed here
  // and registered, so core_done/err/rdata never depend combinationally on
  // the inputs.
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path can leave
    // one unassigned and infer a latch.
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_done_nxt      = 1'b0;
    w_err_nxt       = 1'b0;
    w_rdata_nxt     = '0;
    w_mem_valid_nxt = 1'b0;
    w_mem_we_nxt    = r_mem_we;
    w_mem_adr_nxt   = r_mem_adr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_err_evt       = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (core_req) begin
          if (w_misaligned) begin
            // Rejected without touching the memory port.
            w_state_nxt = S_ERR;
            w_done_nxt  = 1'b1;
            w_err_nxt   = 1'b1;
            w_rdata_nxt = ERR_DATA;
            w_err_evt   = 1'b1;
          end else begin
            w_state_nxt     = S_REQ;
            w_cnt_nxt       = '0;
            w_mem_valid_nxt = 1'b1;
            w_mem_we_nxt    = core_we;
            w_mem_adr_nxt   = core_adr;
            w_mem_wdata_nxt = core_wdata;
          end
        end
      end

      S_REQ: begin
        // Ready is checked first: a ready in the last allowed cycle wins over
        // the timeout.
        if (mem_ready) begin
          w_state_nxt = S_RESP;
          w_done_nxt  = 1'b1;
          w_rdata_nxt = r_mem_we ? '0 : mem_rdata;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_ERR;
          w_done_nxt  = 1'b1;
          w_err_nxt   = 1'b1;
          w_rdata_nxt = ERR_DATA;
          w_err_evt   = 1'b1;
        end else begin
          w_cnt_nxt       = r_cnt + CNT_W'(1);
          w_mem_valid_nxt = 1'b1;
        end
      end

      // RESP and ERR each last one cycle; the pulse was set on entry.
      S_RESP:  w_state_nxt = S_IDLE;
      S_ERR:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_err_cnt_nxt = (w_err_evt && (r_err_cnt != 8'hFF)) ? r_err_cnt + 8'd1
                                                              : r_err_cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
      r_mem_valid <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_adr   <= '0;
      r_mem_wdata <= '0;
      r_err_cnt   <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
      r_rdata     <= w_rdata_nxt;
      r_mem_valid <= w_mem_valid_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_adr   <= w_mem_adr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_err_cnt   <= w_err_cnt_nxt;
    end
  end

  assign core_busy  = r_busy;
  assign core_done  = r_done;
  assign core_err   = r_err;
  assign core_rdata = r_rdata;
  assign mem_valid  = r_mem_valid;
  assign mem_we     = r_mem_we;
  assign mem_adr    = r_mem_adr;
  assign mem_wdata  = r_mem_wdata;
  assign err_count  = r_err_cnt;

endmodule

// File: tb/tb_arm_mem_bridge.sv
// -----------------------------------------------------------------------------
// tb_arm_mem_bridge
//   Self-checking bench for arm_mem_bridge (default parameters). Each
//   transaction's outcome (completion cycle, error flag, read data, number of
//   memory-port cycles, error count) is predicted from the bridge's contract
//   and compared with what the DUT produces. Inputs change and outputs are
//   sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_arm_mem_bridge;

  localparam int          TIMEOUT  = 16;
  localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        core_req = 1'b0;
  logic        core_we = 1'b0;
  logic [31:0] core_adr = '0;
  logic [31:0] core_wdata = '0;
  logic        core_busy, core_done, core_err;
  logic [31:0] core_rdata;
  logic        mem_valid, mem_we;
  logic [31:0] mem_adr, mem_wdata;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [7:0]  err_count;

  int n_pass  = 0;
  int n_total = 0;
  int model_errs = 0;

  arm_mem_bridge #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA), .ALIGN_CHECK(1'b1)
  ) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_adr(core_adr), .core_wdata(core_wdata),
    .core_busy(core_busy), .core_done(core_done), .core_err(core_err), .core_rdata(core_rdata),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .err_count(err_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] sat_count(input int n);
    return (n > 255) ? 8'd255 : 8'(n);
  endfunction

  // One complete core transaction, started at a falling edge with the bridge
  // idle. waits = memory cycles before mem_ready (>= TIMEOUT means never).
  task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] wdata,
                         input logic [31:0] rdat, input int waits, input string tag);
    int          cyc, done_cyc, valid_cycles, exp_cyc, exp_valid;
    logic        got_err, exp_err;
    logic [31:0] got_rdata, exp_rdata;
    bit          bad;

    // Expected outcome from the bridge contract.
    if (adr[1:0] != 2'b00) begin
      exp_cyc = 1; exp_err = 1'b1; exp_rdata = ERR_DATA; exp_valid = 0;
    end else if (waits < TIMEOUT) begin
      exp_cyc = waits + 2; exp_err = 1'b0; exp_rdata = we ? 32'd0 : rdat; exp_valid = waits + 1;
    end else begin
      exp_cyc = TIMEOUT + 1; exp_err = 1'b1; exp_rdata = ERR_DATA; exp_valid = TIMEOUT;
    end
    if (exp_err) model_errs++;

    core_req = 1'b1; core_we = we; core_adr = adr; core_wdata = wdata;
    @(negedge clk);
    // Scramble the core inputs: the bridge must work from its latched copy.
    core_req = 1'b0; core_we = 1'($urandom); core_adr = $urandom; core_wdata = $urandom;
    cyc = 1; done_cyc = -1; valid_cycles = 0; bad = 1'b0;
    got_err = 1'b0; got_rdata = '0;
    while (done_cyc < 0 && cyc <= TIMEOUT + 5) begin
      if (core_done) begin
        done_cyc = cyc; got_err = core_err; got_rdata = core_rdata;
      end else begin
        if (core_busy !== 1'b1) bad = 1'b1;
        if (mem_valid) begin
          if (mem_we !== we || mem_adr !== adr || mem_wdata !== wdata) bad = 1'b1;
          mem_ready = (valid_cycles == waits);
          mem_rdata = (valid_cycles == waits) ? rdat : $urandom;
          valid_cycles++;
        end else begin
          // Noise on the memory side while no request is shown.
          mem_ready = 1'($urandom);
          mem_rdata = $urandom;
        end
        @(negedge clk);
        cyc++;
      end
    end

    n_total++;
    if (done_cyc !== exp_cyc) $display("FAIL %s done_cycle: got %0d expected %0d", tag, done_cyc, exp_cyc);
    else n_pass++;
    n_total++;
    if (got_err !== exp_err) $display("FAIL %s core_err: got %0b expected %0b", tag, got_err, exp_err);
    else n_pass++;
    n_total++;
    if (got_rdata !== exp_rdata) $display("FAIL %s core_rdata: got %h expected %h", tag, got_rdata, exp_rdata);
    else n_pass++;
    n_total++;
    if (valid_cycles !== exp_valid) $display("FAIL %s mem_valid_cycles: got %0d expected %0d", tag, valid_cycles, exp_valid);
    else n_pass++;
    n_total++;
    if (bad !== 1'b0) $display("FAIL %s mem_port_stable_busy: got bad=%0b expected 0", tag, bad);
    else n_pass++;

    @(negedge clk);
    mem_ready = 1'b0;
    n_total++;
    if ({core_done, core_busy, mem_valid} !== 3'b000)
      $display("FAIL %s after_done_idle: got done/busy/valid=%b expected 000", tag, {core_done, core_busy, mem_valid});
    else n_pass++;
    n_total++;
    if (err_count !== sat_count(model_errs))
      $display("FAIL %s err_count: got %0d expected %0d", tag, err_count, sat_count(model_errs));
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if ({core_busy, core_done, core_err, core_rdata, mem_valid, mem_we, mem_adr, mem_wdata, err_count} !== 109'd0)
      $display("FAIL reset_outputs: got busy=%b done=%b valid=%b err_count=%0d expected all zero",
               core_busy, core_done, mem_valid, err_count);
    else n_pass++;
    reset = 1'b1;
    model_errs = 0;
    @(negedge clk);
  endtask

  task automatic test_read_zero_wait();
    run_txn(1'b0, 32'h40, $urandom, 32'h1234, 0, "read_zero_wait");
  endtask

  task automatic test_write_waits();
    run_txn(1'b1, 32'h80, 32'hCAFEF00D, $urandom, 3, "write_3_waits");
  endtask

  task automatic test_timeout();
    run_txn(1'b0, 32'h200, $urandom, 32'h55AA_1234, TIMEOUT, "timeout");
    run_txn(1'b0, 32'h204, $urandom, 32'h0BAD_F00D, TIMEOUT - 1, "ready_last_cycle");
  endtask

  task automatic test_misaligned();
    run_txn(1'b0, 32'h42, $urandom, $urandom, 0, "misaligned");
  endtask

  task automatic test_reset_mid_req();
    logic [108:0] snap;
    core_req = 1'b1; core_we = 1'b0; core_adr = 32'h100; core_wdata = $urandom;
    @(negedge clk);                       // first REQ cycle
    core_req = 1'b0; mem_ready = 1'b0;
    @(negedge clk);                       // second REQ cycle
    n_total++;
    if (mem_valid !== 1'b1) $display("FAIL reset_mid pre_valid: got %b expected 1", mem_valid);
    else n_pass++;
    reset = 1'b0;
    @(negedge clk);
    snap = {core_busy, core_done, core_err, core_rdata, mem_valid, mem_we, mem_adr, mem_wdata, err_count};
    n_total++;
    if (snap !== 109'd0) $display("FAIL reset_mid outputs: got %h expected 0", snap);
    else n_pass++;
    mem_ready = 1'b1;                     // late ready must not resurrect the request
    @(negedge clk);
    n_total++;
    if ({core_done, mem_valid} !== 2'b00) $display("FAIL reset_mid no_done: got %b expected 00", {core_done, mem_valid});
    else n_pass++;
    reset = 1'b1; mem_ready = 1'b0;
    model_errs = 0;
    @(negedge clk);
    run_txn(1'b1, 32'h104, 32'h1357_9BDF, $urandom, 1, "after_reset_write");
  endtask

  // Request held high throughout: only requests seen in IDLE are accepted.
  task automatic test_back_to_back();
    int          accepts = 0;
    int          dones = 0;
    int          since = -1;
    logic [31:0] acc_adr = '0;
    mem_ready = 1'b1; mem_rdata = 32'hA5A5_3C3C;
    core_req = 1'b1; core_we = 1'b0;
    core_adr = {$urandom} & 32'hFFFF_FFFC;
    for (int i = 0; i < 30; i++) begin
      if (since >= 0) since++;
      if (since == 1) begin
        n_total++;
        if (mem_valid !== 1'b1 || mem_adr !== acc_adr)
          $display("FAIL b2b accepted_adr: got valid=%b adr=%h expected valid=1 adr=%h", mem_valid, mem_adr, acc_adr);
        else n_pass++;
      end
      if (core_done) begin
        dones++;
        n_total++;
        if (since !== 2 || core_err !== 1'b0 || core_rdata !== 32'hA5A5_3C3C)
          $display("FAIL b2b done: got since=%0d err=%b rdata=%h expected since=2 err=0 rdata=a5a53c3c",
                   since, core_err, core_rdata);
        else n_pass++;
      end
      if (!core_busy) begin
        acc_adr = core_adr; since = 0; accepts++;
      end
      @(negedge clk);
      core_adr = {$urandom} & 32'hFFFF_FFFC;
    end
    core_req = 1'b0; mem_ready = 1'b0;
    n_total++;
    if (accepts !== 10) $display("FAIL b2b accepts: got %0d expected 10", accepts);
    else n_pass++;
    n_total++;
    if (dones !== 10) $display("FAIL b2b dones: got %0d expected 10", dones);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [31:0] adr;
      int          waits;
      adr = {$urandom} & 32'hFFFF_FFFC;
      if ($urandom_range(5) == 0) adr[1:0] = 2'($urandom_range(3, 1));
      waits = ($urandom_range(7) == 0) ? $urandom_range(TIMEOUT + 2, TIMEOUT - 1) : $urandom_range(4);
      run_txn(1'($urandom), adr, $urandom, $urandom, waits, "random");
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) begin
      logic [31:0] adr;
      adr = $urandom;
      if (adr[1:0] == 2'b00) adr[0] = 1'b1;
      run_txn(1'($urandom), adr, $urandom, $urandom, 0, "saturate");
    end
    n_total++;
    if (err_count !== 8'd255) $display("FAIL saturation_final: got %0d expected 255", err_count);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_waits();
    test_timeout();
    test_misaligned();
    test_reset_mid_req();
    test_back_to_back();
    test_random();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
